// File: rtl/smc_step_pulse_gen.sv
// Step/direction pulse generator with Avalon-MM register slave and done interrupt.
// Optional dropped-tick overrun counter enabled by defining SMC_STEP_OVERRUN_EN.
module smc_step_pulse_gen #(
    parameter int PULSE_W = 50,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        step,
    output logic        dir,
    output logic        busy
);

    // state     | meaning
    // IDLE      | no move active, waiting for START
    // WAIT_TICK | move active, next tick launches a STEP pulse
    // PULSE     | STEP high, counting down PULSE_W cycles
    typedef enum logic [1:0] {IDLE, WAIT_TICK, PULSE} state_t;

    localparam int PC_W = $clog2(PULSE_W);

    state_t             state_q;
    logic [PC_W-1:0]    pcnt_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   remain_q;
    logic               irq_en_q;
    logic               dir_cfg_q;
    logic               dir_q;
    logic               step_q;
    logic               done_q;
    logic               done_d;
    logic               done_set;
    logic               stop_pend_q;
    logic [15:0]        readdata_q;
    logic [15:0]        rd_mux;
    logic               ovr_flag;
    logic [7:0]         ovr_cnt;

    logic wr, wr_status, wr_ctrl, start_req, stop_req;

    assign wr        = chipselect & ~write_n;
    assign wr_status = wr && (address == 3'd0);
    assign wr_ctrl   = wr && (address == 3'd1);
    assign stop_req  = wr_ctrl && writedata[3];
    assign start_req = wr_ctrl && writedata[2] && !writedata[3];

    // A pending or same-cycle STOP ends the move without flagging done.
    always_comb begin
        done_set = 1'b0;
        case (state_q)
            IDLE:  done_set = start_req && (target_q == '0);
            PULSE: done_set = (pcnt_q == '0) && (remain_q == '0) && !stop_pend_q && !stop_req;
            default: done_set = 1'b0;
        endcase
        done_d = done_set | (done_q & ~wr_status);
    end

    always_comb begin
        case (address)
            3'd0:    rd_mux = {13'd0, ovr_flag, busy, done_q};
            3'd1:    rd_mux = {14'd0, dir_cfg_q, irq_en_q};
            3'd2:    rd_mux = target_q[15:0];
            3'd3:    rd_mux = target_q[CNT_W-1:16];
            3'd4:    rd_mux = remain_q[15:0];
            3'd5:    rd_mux = remain_q[CNT_W-1:16];
            3'd6:    rd_mux = {8'd0, ovr_cnt};
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pcnt_q      <= '0;
            target_q    <= '0;
            remain_q    <= '0;
            irq_en_q    <= 1'b0;
            dir_cfg_q   <= 1'b0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            readdata_q  <= 16'd0;
        end else begin
            readdata_q <= rd_mux;
            done_q     <= done_d;
            if (wr_ctrl) begin
                irq_en_q  <= writedata[0];
                dir_cfg_q <= writedata[1];
            end
            if (wr && address == 3'd2) target_q[15:0]      <= writedata;
            if (wr && address == 3'd3) target_q[CNT_W-1:16] <= writedata;

            case (state_q)
                IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (start_req && target_q != '0) begin
                        state_q  <= WAIT_TICK;
                        remain_q <= target_q;
                        dir_q    <= writedata[1];
                    end
                end
                WAIT_TICK: begin
                    if (stop_req) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        state_q <= PULSE;
                        step_q  <= 1'b1;
                        pcnt_q  <= PC_W'(PULSE_W - 1);
                        if (remain_q != '0) remain_q <= remain_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (stop_req) stop_pend_q <= 1'b1;
                    if (pcnt_q == '0) begin
                        step_q      <= 1'b0;
                        stop_pend_q <= 1'b0;
                        state_q     <= (stop_pend_q || stop_req || remain_q == '0) ? IDLE : WAIT_TICK;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SMC_STEP_OVERRUN_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d, ovr_base;
    logic       ovr_flag_q, ovr_flag_d;
    logic       tick_drop;

    // Ticks lost to an active pulse or to the START cycle itself.
    always_comb begin
        tick_drop  = tick && ((state_q == PULSE) ||
                              (state_q == IDLE && start_req && target_q != '0));
        ovr_base   = wr_status ? 8'd0 : ovr_cnt_q;
        ovr_cnt_d  = (tick_drop && ovr_base != 8'hFF) ? ovr_base + 8'd1 : ovr_base;
        ovr_flag_d = tick_drop | (ovr_flag_q & ~wr_status);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_q  <= 8'd0;
            ovr_flag_q <= 1'b0;
        end else begin
            ovr_cnt_q  <= ovr_cnt_d;
            ovr_flag_q <= ovr_flag_d;
        end
    end

    assign ovr_flag = ovr_flag_q;
    assign ovr_cnt  = ovr_cnt_q;
`else
    assign ovr_flag = 1'b0;
    assign ovr_cnt  = 8'd0;
`endif

    assign readdata = readdata_q;
    assign irq      = done_q & irq_en_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign busy     = (state_q != IDLE);

endmodule
